// File: rtl/adder_sum_accumulator.sv
// Accumulates a commanded number of 9-bit adder results ({cout,sum}) into a wider total.
// Optional macro ADDER_SUM_ACCUMULATOR_SATURATE_EN clamps the total at all-ones instead of wrapping.
module adder_sum_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic             overflow_nxt;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   acc_sum;

  assign operand = ACC_W'({cout, sum});
  assign acc_sum = {1'b0, acc_out} + {1'b0, operand};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      acc_out   <= acc_nxt;
      overflow  <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    acc_nxt       = acc_out;
    overflow_nxt  = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt      = '0;
          overflow_nxt = 1'b0;
          if (count != '0) begin
            remaining_nxt = count;
            state_nxt     = ACCUM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt       = acc_sum[ACC_W-1:0];
          remaining_nxt = remaining - 1'b1;
          if (acc_sum[ACC_W]) begin
            overflow_nxt = 1'b1;
`ifdef ADDER_SUM_ACCUMULATOR_SATURATE_EN
            acc_nxt = '1;
`else
            acc_nxt = acc_sum[ACC_W-1:0];
`endif
          end
          if (remaining == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        // A start arriving while the result drains is deliberately dropped.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Randomized bench for adder_sum_accumulator; expected totals come from a plain integer sum model.
// Follows ADDER_SUM_ACCUMULATOR_SATURATE_EN to choose wrap or clamp expectations.
module tb_adder_sum_accumulator;

  localparam int IN_W  = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int MAXV  = 65535;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  opQ[$];
  bit          satMode;

  adder_sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // validMode: 0 always valid, 1 random, 2 one valid then two idle cycles
  task automatic applyStimulus(input int cnt, input int validMode, input int holdCycles);
    int accepted = 0;
    int cycles = 0;
    int total = 0;
    logic [8:0] op;
    logic [15:0] expAcc;
    bit v, xfer;
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(cnt);
    @(negedge clk);
    start = 1'b0;
    count = CNT_W'($urandom);
    while (accepted < cnt) begin
      if (cycles >= 5000) begin
        checkOutput("xfer_timeout", 32'(accepted), 32'(cnt));
        break;
      end
      case (validMode)
        0: v = 1'b1;
        1: v = ($urandom_range(1, 0) == 1);
        default: v = ((cycles % 3) == 0);
      endcase
      op = (opQ.size() > 0) ? opQ[0] : 9'($urandom);
      in_valid = v;
      {cout, sum} = op;
      checkOutput("in_ready_accum", 32'(in_ready), 32'd1);
      xfer = v && in_ready;
      @(negedge clk);
      if (xfer) begin
        total += int'(op);
        accepted++;
        if (opQ.size() > 0) void'(opQ.pop_front());
      end
      cycles++;
    end
    in_valid = 1'b0;
    if (total > MAXV) expAcc = satMode ? 16'hFFFF : 16'(total % 65536);
    else expAcc = 16'(total);
    checkOutput("done_out_valid", 32'(out_valid), 32'd1);
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_acc", 32'(acc_out), 32'(expAcc));
    checkOutput("done_overflow", 32'(overflow), 32'(total > MAXV));
    for (int h = 0; h < holdCycles; h++) begin
      out_ready = 1'b0;
      start = (h == 0);
      count = CNT_W'(7);
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_acc", 32'(acc_out), 32'(expAcc));
    end
    out_ready = 1'b1;
    start = 1'b1;
    count = CNT_W'(3);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_acc_kept", 32'(acc_out), 32'(expAcc));
    @(negedge clk);
    checkOutput("start_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
`ifdef ADDER_SUM_ACCUMULATOR_SATURATE_EN
    satMode = 1'b1;
`else
    satMode = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b1; count = 8'd5; in_valid = 1'b1;
    sum = 8'hAA; cout = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acc", 32'(acc_out), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;

    opQ = '{9'h010, 9'h1FF, 9'h001};
    applyStimulus(3, 0, 0);
    checkOutput("basic_const", 32'(acc_out), 32'h0210);

    applyStimulus(2, 2, 5);

    opQ.delete();
    for (int i = 0; i < 200; i++) opQ.push_back(9'h1FF);
    applyStimulus(200, 0, 1);
    checkOutput("ovf_const", 32'(acc_out), satMode ? 32'hFFFF : 32'((200 * 511) % 65536));
    checkOutput("ovf_flag", 32'(overflow), 32'd1);

    applyStimulus(0, 0, 2);
    checkOutput("zero_acc", 32'(acc_out), 32'd0);

    // reset arriving mid-run drops the partial total
    @(negedge clk);
    start = 1'b1; count = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; {cout, sum} = 9'h0C3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_acc", 32'(acc_out), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_out", 32'(out_valid), 32'd0);
    end
    opQ.push_back(9'h005);
    applyStimulus(1, 0, 0);
    checkOutput("midrst_new_acc", 32'(acc_out), 32'd5);

    for (int r = 0; r < 12; r++)
      applyStimulus($urandom_range(20, 0), $urandom_range(2, 0), $urandom_range(3, 0));
    applyStimulus(255, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
